seg_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment scan controller. Drives NUM_DIGITS common-anode digits from a packed bank of 5-bit glyph codes, with a frame-synchronous double buffer (no tearing), per-slot PWM brightness, anti-ghosting guard blanking, leading-zero suppression and selectable pin polarity. It sits between the game/score logic and the board's AN/seg pins, generalising the fixed 8-digit, fixed-rate, hex-only display driver.

---
 rtl/seg_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: time-slices NUM_DIGITS common-anode digits
// from a frame-synchronous double-buffered glyph bank with PWM dimming and zero blanking.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int PRESCALE_W = 17,
    parameter bit ACTIVE_LOW = 1'b1,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic [3:0]              brightness,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_done
);

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_POL   = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]            SEG_POL  = {7{ACTIVE_LOW}};

    logic [PRESCALE_W-1:0]   prescaler;
    logic [IDX_W-1:0]        idx;
    logic [5*NUM_DIGITS-1:0] pend_codes;
    logic [5*NUM_DIGITS-1:0] shadow_codes;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    pend_valid;

    logic                  slot_end;
    logic                  frame_boundary;
    logic [3:0]            phase;
    logic                  anode_on;
    logic [NUM_DIGITS-1:0] suppress;
    logic [4:0]            cur_code;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic                  all_zero;

    assign slot_end       = &prescaler;
    assign frame_boundary = slot_end && (idx == LAST_IDX);
    assign phase          = prescaler[PRESCALE_W-1 -: 4];
    // Phase 0 of every slot is a guard gap so the previous digit's segments never ghost.
    assign anode_on       = (phase != 4'd0) && (phase <= brightness);

    function automatic logic [6:0] glyph(input logic [4:0] code);
        logic [6:0] g;
        case (code)
            5'h00: g = 7'h3F;
            5'h01: g = 7'h06;
            5'h02: g = 7'h5B;
            5'h03: g = 7'h4F;
            5'h04: g = 7'h66;
            5'h05: g = 7'h6D;
            5'h06: g = 7'h7D;
            5'h07: g = 7'h07;
            5'h08: g = 7'h7F;
            5'h09: g = 7'h6F;
            5'h0A: g = 7'h77;
            5'h0B: g = 7'h7C;
            5'h0C: g = 7'h39;
            5'h0D: g = 7'h5E;
            5'h0E: g = 7'h79;
            5'h0F: g = 7'h71;
            5'h11: g = 7'h40;
            5'h12: g = 7'h6D;
            5'h13: g = 7'h54;
            5'h14: g = 7'h77;
            5'h15: g = 7'h79;
            5'h16: g = 7'h38;
            5'h17: g = 7'h73;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    // Walk from the top digit down; a digit is blanked only while every code above it is zero.
    always_comb begin
        all_zero = 1'b1;
        suppress = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero    = all_zero && (shadow_codes[5*i +: 5] == 5'd0);
            suppress[i] = lz_en && all_zero && (i != 0);
        end
    end

    always_comb begin
        cur_code  = 5'h10;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_next   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_code   = shadow_codes[5*i +: 5];
                cur_dp     = shadow_dp[i];
                cur_blank  = suppress[i];
                an_next[i] = anode_on;
            end
        end
        seg_next = cur_blank ? 7'h00 : glyph(cur_code);
        dp_next  = cur_dp && !cur_blank;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            idx       <= '0;
        end else begin
            prescaler <= prescaler + PRESCALE_W'(1);
            if (slot_end) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // A load landing exactly on the frame boundary bypasses the pending stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_codes   <= '0;
            pend_dp      <= '0;
            pend_valid   <= 1'b0;
            shadow_codes <= {NUM_DIGITS{5'h10}};
            shadow_dp    <= '0;
        end else begin
            if (load && frame_boundary) begin
                shadow_codes <= digits;
                shadow_dp    <= dp_in;
                pend_valid   <= 1'b0;
            end else if (frame_boundary && pend_valid) begin
                shadow_codes <= pend_codes;
                shadow_dp    <= pend_dp;
                pend_valid   <= 1'b0;
            end
            if (load && !frame_boundary) begin
                pend_codes <= digits;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            AN         <= AN_POL;
            seg        <= SEG_POL;
            dp         <= ACTIVE_LOW;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            AN         <= an_next ^ AN_POL;
            seg        <= seg_next ^ SEG_POL;
            dp         <= dp_next ^ ACTIVE_LOW;
            digit_idx  <= idx;
            frame_done <= frame_boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: an 8-digit active-low and a 5-digit active-high instance share
// stimulus and are compared every cycle against a time-based reference model.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] digits;
    logic [7:0]  dp_in;
    logic        load;
    logic [3:0]  brightness;
    logic        lz_en;

    logic [7:0] an_a;
    logic [6:0] seg_a;
    logic       dp_a;
    logic [2:0] idx_a;
    logic       fd_a;
    logic [4:0] an_b;
    logic [6:0] seg_b;
    logic       dp_b;
    logic [2:0] idx_b;
    logic       fd_b;

    seg_scan_ctrl #(.NUM_DIGITS(8), .PRESCALE_W(4), .ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in), .load(load),
        .brightness(brightness), .lz_en(lz_en), .AN(an_a), .seg(seg_a), .dp(dp_a),
        .digit_idx(idx_a), .frame_done(fd_a)
    );

    seg_scan_ctrl #(.NUM_DIGITS(5), .PRESCALE_W(4), .ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst(rst), .digits(digits[24:0]), .dp_in(dp_in[4:0]), .load(load),
        .brightness(brightness), .lz_en(lz_en), .AN(an_b), .seg(seg_b), .dp(dp_b),
        .digit_idx(idx_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    int         n_vectors;
    int         n_miscompares;
    int         k;
    int         nd [2];
    bit         al [2];
    logic [6:0] glyph_tab [32];
    logic [4:0] m_shadow [2][8];
    logic       m_sdp [2][8];
    logic [4:0] m_pend [2][8];
    logic       m_pdp [2][8];
    bit         m_flag [2];
    logic [31:0] e_an [2];
    logic [31:0] e_seg [2];
    logic [31:0] e_dp [2];
    logic [31:0] e_idx [2];
    logic [31:0] e_fd [2];
    logic [39:0] cur_digits;
    logic [7:0]  cur_dp;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vectors++;
        if (obs !== expv) begin
            n_miscompares++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at cycle %0d", tag, obs, expv, k);
        end
    endtask

    function automatic bit isBoundary(input int d);
        return ((k % 16) == 15) && (((k / 16) % nd[d]) == nd[d] - 1);
    endfunction

    task automatic modelReset();
        k = 0;
        for (int d = 0; d < 2; d++) begin
            m_flag[d] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_shadow[d][i] = 5'h10;
                m_sdp[d][i]    = 1'b0;
                m_pend[d][i]   = 5'h00;
                m_pdp[d][i]    = 1'b0;
            end
        end
    endtask

    // Expected pins for the state at cycle k: slot = k/16, phase = k%16.
    task automatic computeExpected();
        for (int d = 0; d < 2; d++) begin
            int          n;
            int          p;
            int          ix;
            bit          allz;
            bit          sup;
            logic [31:0] g;
            logic [31:0] dpv;
            logic [31:0] an;
            logic [31:0] mask;
            n    = nd[d];
            p    = k % 16;
            ix   = (k / 16) % n;
            allz = 1'b1;
            for (int j = n - 1; j >= ix; j--) begin
                if (m_shadow[d][j] != 5'd0) allz = 1'b0;
            end
            sup  = lz_en && (ix != 0) && allz;
            g    = sup ? 32'd0 : 32'(glyph_tab[m_shadow[d][ix]]);
            dpv  = sup ? 32'd0 : 32'(m_sdp[d][ix]);
            an   = ((p != 0) && (p <= int'(brightness))) ? (32'd1 << ix) : 32'd0;
            mask = (32'd1 << n) - 32'd1;
            if (al[d]) begin
                an  = ~an & mask;
                g   = ~g & 32'h7F;
                dpv = dpv ^ 32'd1;
            end
            e_an[d]  = an;
            e_seg[d] = g;
            e_dp[d]  = dpv;
            e_idx[d] = 32'(ix);
            e_fd[d]  = 32'(isBoundary(d));
        end
    endtask

    task automatic modelEdge();
        for (int d = 0; d < 2; d++) begin
            bit bnd;
            bnd = isBoundary(d);
            if (load && bnd) begin
                for (int i = 0; i < nd[d]; i++) begin
                    m_shadow[d][i] = digits[5*i +: 5];
                    m_sdp[d][i]    = dp_in[i];
                end
                m_flag[d] = 1'b0;
            end else if (bnd && m_flag[d]) begin
                for (int i = 0; i < nd[d]; i++) begin
                    m_shadow[d][i] = m_pend[d][i];
                    m_sdp[d][i]    = m_pdp[d][i];
                end
                m_flag[d] = 1'b0;
            end
            if (load && !bnd) begin
                for (int i = 0; i < nd[d]; i++) begin
                    m_pend[d][i] = digits[5*i +: 5];
                    m_pdp[d][i]  = dp_in[i];
                end
                m_flag[d] = 1'b1;
            end
        end
        k++;
    endtask

    task automatic applyStimulus(input logic ld, input logic [39:0] dg, input logic [7:0] dpv,
                                 input logic [3:0] br, input logic lz);
        load       = ld;
        digits     = dg;
        dp_in      = dpv;
        brightness = br;
        lz_en      = lz;
        computeExpected();
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput("AN_a", 32'(an_a), e_an[0]);
        checkOutput("seg_a", 32'(seg_a), e_seg[0]);
        checkOutput("dp_a", 32'(dp_a), e_dp[0]);
        checkOutput("idx_a", 32'(idx_a), e_idx[0]);
        checkOutput("frame_done_a", 32'(fd_a), e_fd[0]);
        checkOutput("AN_b", 32'(an_b), e_an[1]);
        checkOutput("seg_b", 32'(seg_b), e_seg[1]);
        checkOutput("dp_b", 32'(dp_b), e_dp[1]);
        checkOutput("idx_b", 32'(idx_b), e_idx[1]);
        checkOutput("frame_done_b", 32'(fd_b), e_fd[1]);
        load = 1'b0;
    endtask

    task automatic loadDigits(input logic [39:0] dg, input logic [7:0] dpv);
        cur_digits = dg;
        cur_dp     = dpv;
        applyStimulus(1'b1, dg, dpv, brightness, lz_en);
    endtask

    task automatic runIdle(input int n, input logic [3:0] br, input logic lz);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, cur_digits, cur_dp, br, lz);
    endtask

    task automatic applyReset();
        rst  = 1'b1;
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_AN_a", 32'(an_a), 32'hFF);
            checkOutput("rst_seg_a", 32'(seg_a), 32'h7F);
            checkOutput("rst_dp_a", 32'(dp_a), 32'h1);
            checkOutput("rst_idx_a", 32'(idx_a), 32'h0);
            checkOutput("rst_fd_a", 32'(fd_a), 32'h0);
            checkOutput("rst_AN_b", 32'(an_b), 32'h00);
            checkOutput("rst_seg_b", 32'(seg_b), 32'h00);
            checkOutput("rst_dp_b", 32'(dp_b), 32'h0);
        end
        rst = 1'b0;
        modelReset();
    endtask

    function automatic logic [39:0] packDigits(input int d7, input int d6, input int d5, input int d4,
                                               input int d3, input int d2, input int d1, input int d0);
        return {5'(d7), 5'(d6), 5'(d5), 5'(d4), 5'(d3), 5'(d2), 5'(d1), 5'(d0)};
    endfunction

    function automatic logic [39:0] randomDigits();
        logic [39:0] v;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0:       v[5*i +: 5] = 5'($urandom_range(0, 31));
                1:       v[5*i +: 5] = 5'd0;
                default: v[5*i +: 5] = 5'($urandom_range(0, 9));
            endcase
        end
        return v;
    endfunction

    initial begin
        logic [7:0] gv [32];
        gv = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71,
               8'h00, 8'h40, 8'h6D, 8'h54, 8'h77, 8'h79, 8'h38, 8'h73,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 32; i++) glyph_tab[i] = gv[i][6:0];
        nd            = '{8, 5};
        al            = '{1'b1, 1'b0};
        n_vectors     = 0;
        n_miscompares = 0;
        cur_digits    = '0;
        cur_dp        = '0;
        digits        = '0;
        dp_in         = '0;
        load          = 1'b0;
        brightness    = 4'd15;
        lz_en         = 1'b0;
        modelReset();

        applyReset();
        runIdle(140, 4'd15, 1'b0);

        // Scan order with digits 7..0 showing 7..0.
        loadDigits(packDigits(7, 6, 5, 4, 3, 2, 1, 0), 8'b0000_0100);
        runIdle(300, 4'd15, 1'b0);

        // Mid-frame load: old glyphs persist until the boundary.
        while ((k % 128) != 40) runIdle(1, 4'd15, 1'b0);
        loadDigits(packDigits(8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h11, 8'h12), 8'b1000_0001);
        runIdle(20, 4'd15, 1'b0);
        loadDigits(packDigits(8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h09, 8'h08, 8'h10), 8'b0101_0101);
        runIdle(250, 4'd15, 1'b0);

        // Load exactly on the boundary cycle of the 8-digit instance.
        while (!isBoundary(0)) runIdle(1, 4'd15, 1'b0);
        loadDigits(packDigits(1, 2, 3, 4, 5, 6, 7, 8), 8'b0010_0000);
        runIdle(160, 4'd15, 1'b0);

        // Brightness extremes.
        runIdle(160, 4'd0, 1'b0);
        runIdle(160, 4'd4, 1'b0);

        // Leading-zero suppression patterns.
        loadDigits(packDigits(0, 0, 0, 0, 0, 1, 0, 5), 8'b1111_1111);
        runIdle(300, 4'd15, 1'b1);
        runIdle(140, 4'd15, 1'b0);
        loadDigits(packDigits(0, 0, 0, 0, 0, 0, 0, 0), 8'b0000_0000);
        runIdle(300, 4'd15, 1'b1);
        runIdle(140, 4'd15, 1'b0);

        // Unused glyph codes and blank codes as non-zero for suppression.
        loadDigits(packDigits(8'h1F, 8'h1F, 8'h10, 8'h00, 8'h1F, 8'h18, 8'h00, 8'h1F), 8'b0000_0000);
        runIdle(300, 4'd9, 1'b1);

        // Reset in the middle of a frame with a load still pending.
        runIdle(37, 4'd15, 1'b0);
        loadDigits(packDigits(9, 9, 9, 9, 9, 9, 9, 9), 8'hFF);
        runIdle(5, 4'd15, 1'b0);
        applyReset();
        runIdle(200, 4'd15, 1'b0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            logic ld;
            ld = ($urandom_range(0, 49) == 0) || (isBoundary(0) && ($urandom_range(0, 2) == 0));
            if (ld) begin
                cur_digits = randomDigits();
                cur_dp     = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 29) == 0) brightness = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) lz_en = ~lz_en;
            applyStimulus(ld, cur_digits, cur_dp, brightness, lz_en);
        end

        $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
